// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between fetch and memory stage.
// Memory stage wins contention; a streak limit guarantees fetch progress; read data is steered back to its issuer.
module mem_port_arbiter #(
    parameter int MAX_M_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic [31:0] m_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m
);
    typedef enum logic [1:0] {IDLE, RD_IF, RD_M} owner_t;
    localparam logic [3:0] MAX_STREAK = 4'(MAX_M_STREAK);
    owner_t owner, ownerNext;
    logic [3:0] streak, streakNext;
    logic ifWins;
    always_comb begin
        ifWins = if_req & (~m_req | (streak >= MAX_STREAK));
        if_gnt = ~rst & ifWins;
        m_gnt = ~rst & m_req & ~ifWins;
        mem_en = if_gnt | m_gnt;
        mem_we = m_gnt & m_we;
        mem_addr = m_gnt ? m_addr : if_addr;
        mem_wdata = m_wdata;
        stall_f = if_req & ~if_gnt;
        stall_m = m_req & ~m_gnt;
        if_rvalid = owner == RD_IF;
        m_rvalid = owner == RD_M;
        if_rdata = mem_rdata;
        m_rdata = mem_rdata;
        streakNext = (if_gnt | ~if_req) ? 4'd0 : (m_gnt ? streak + 4'd1 : streak);
        ownerNext = if_gnt ? RD_IF : ((m_gnt & ~m_we) ? RD_M : IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= 4'd0;
            owner <= IDLE;
        end else begin
            streak <= streakNext;
            owner <= ownerNext;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant priority, streak guard, read steering and reset.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifReq = 1'b0, mReq = 1'b0, mWe = 1'b0;
    logic [31:0] ifAddr = '0, mAddr = '0, mWdata = '0, memRdata = '0;
    logic ifGnt, ifRvalid, mGnt, mRvalid, memEn, memWe, stallF, stallM;
    logic [31:0] ifRdata, mRdata, memAddr, memWdata;
    int tests = 0, fails = 0;
    logic [9:0] order = 10'b1000010000;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_M_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_rvalid(ifRvalid), .if_rdata(ifRdata),
        .m_req(mReq), .m_we(mWe), .m_addr(mAddr), .m_wdata(mWdata), .m_gnt(mGnt),
        .m_rvalid(mRvalid), .m_rdata(mRdata),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
        .stall_f(stallF), .stall_m(stallM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        // reset: a granted load's rvalid is killed by an asynchronous reset
        ifReq = 1'b1; ifAddr = 32'h44; mReq = 1'b1; mWe = 1'b0; mAddr = 32'h40;
        #1;
        check("rst_pre_mgnt", mGnt, 1);
        check("rst_pre_ifgnt", ifGnt, 0);
        tick();
        check("rst_pre_mrvalid", mRvalid, 1);
        rst = 1'b1;
        #1;
        check("rst_ifgnt", ifGnt, 0);
        check("rst_mgnt", mGnt, 0);
        check("rst_memen", memEn, 0);
        check("rst_memwe", memWe, 0);
        check("rst_ifrvalid", ifRvalid, 0);
        check("rst_mrvalid", mRvalid, 0);
        check("rst_stallf", stallF, 1);
        check("rst_stallm", stallM, 1);
        tick();
        rst = 1'b0;
        #1;
        check("rst_rel_mgnt", mGnt, 1);
        check("rst_rel_stallm", stallM, 0);
        check("rst_rel_stallf", stallF, 1);
        ifReq = 1'b0; mReq = 1'b0;
        repeat (2) tick();
        // lone fetch
        ifReq = 1'b1; ifAddr = 32'h68;
        #1;
        check("lf_ifgnt", ifGnt, 1);
        check("lf_memen", memEn, 1);
        check("lf_memwe", memWe, 0);
        check("lf_addr", memAddr, 32'h68);
        tick();
        ifReq = 1'b0; memRdata = 32'h00500093;
        #1;
        check("lf_ifrvalid", ifRvalid, 1);
        check("lf_ifrdata", ifRdata, 32'h00500093);
        check("lf_mrvalid", mRvalid, 0);
        tick();
        // store then load to the same address
        mReq = 1'b1; mWe = 1'b1; mAddr = 32'h66; mWdata = 32'h67;
        #1;
        check("st_mgnt", mGnt, 1);
        check("st_memwe", memWe, 1);
        check("st_addr", memAddr, 32'h66);
        check("st_wdata", memWdata, 32'h67);
        tick();
        mWe = 1'b0;
        #1;
        check("ld_mrvalid_after_st", mRvalid, 0);
        check("ld_memwe", memWe, 0);
        check("ld_mgnt", mGnt, 1);
        tick();
        mReq = 1'b0; memRdata = 32'h67;
        #1;
        check("ld_mrvalid", mRvalid, 1);
        check("ld_mrdata", mRdata, 32'h67);
        tick();
        // starvation guard: M,M,M,M,IF,M,M,M,M,IF
        ifReq = 1'b1; ifAddr = 32'h100; mReq = 1'b1; mWe = 1'b0; mAddr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("sg_ifgnt%0d", i), ifGnt, order[i]);
            check($sformatf("sg_mgnt%0d", i), mGnt, !order[i]);
            check($sformatf("sg_stallf%0d", i), stallF, !order[i]);
            check($sformatf("sg_addr%0d", i), memAddr, order[i] ? 32'h100 : 32'h200);
            tick();
        end
        // read steering under alternation
        ifReq = 1'b0; mAddr = 32'h10;
        #1;
        check("rs0_mgnt", mGnt, 1);
        check("rs0_addr", memAddr, 32'h10);
        tick();
        mReq = 1'b0; ifReq = 1'b1; ifAddr = 32'h20; memRdata = 32'hAAAA5555;
        #1;
        check("rs1_mrvalid", mRvalid, 1);
        check("rs1_ifrvalid", ifRvalid, 0);
        check("rs1_ifgnt", ifGnt, 1);
        check("rs1_addr", memAddr, 32'h20);
        check("rs1_mrdata", mRdata, 32'hAAAA5555);
        tick();
        ifReq = 1'b0; memRdata = 32'h12345678;
        #1;
        check("rs2_ifrvalid", ifRvalid, 1);
        check("rs2_mrvalid", mRvalid, 0);
        check("rs2_ifrdata", ifRdata, 32'h12345678);
        tick();
        // idle
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("idle_memen%0d", i), memEn, 0);
            check($sformatf("idle_memwe%0d", i), memWe, 0);
            check($sformatf("idle_streak%0d", i), dut.streak, 0);
            check($sformatf("idle_rvalid%0d", i), {ifRvalid, mRvalid}, 0);
            check($sformatf("idle_stall%0d", i), {stallF, stallM}, 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port synchronous memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined RISC-V core. The memory stage has priority, and a streak counter guarantees fetch forward progress. Read data is steered back to the requester that issued the read, and per-stage stall signals go to the pipeline control. The block sits between the `fetch_cycle`/`memory_cycle` stages and the shared memory macro.

## Interface
Parameters:
- `MAX_M_STREAK`, default 4: maximum consecutive memory-stage grants while fetch is waiting; range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request; held with `if_addr` stable until granted.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid this cycle.
- `if_rdata` out 32: instruction word.
- `m_req` in 1: memory-stage request; held with `m_we`/`m_addr`/`m_wdata` stable until granted.
- `m_we` in 1: 1 = store, 0 = load.
- `m_addr` in 32: memory-stage byte address (ALU result).
- `m_wdata` in 32: store data.
- `m_gnt` out 1: memory-stage request accepted this cycle.
- `m_rvalid` out 1: `m_rdata` valid this cycle; loads only.
- `m_rdata` out 32: load data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_en`=1 with `mem_we`=0.
- `stall_f` out 1: `if_req & ~if_gnt`.
- `stall_m` out 1: `m_req & ~m_gnt`.

## Operation
Grant decision is combinational from `if_req`, `m_req` and `streak`:
- Only one requester active: that requester is granted.
- Both active and `streak < MAX_M_STREAK`: memory stage granted.
- Both active and `streak == MAX_M_STREAK`: fetch granted.
- Neither active: no grant; `mem_en`=0.
- At most one of `if_gnt`/`m_gnt` is high in any cycle.

Memory port outputs:
- `mem_en` = `if_gnt | m_gnt`.
- `mem_we` = `m_gnt & m_we`.
- `mem_addr` = address of the granted requester.
- `mem_wdata` = `m_wdata`.
- When `mem_en`=0, `mem_we`=0; `mem_addr`/`mem_wdata` are don't-care but must not contain X.

Streak counter `streak` (4 bits):
- `m_gnt & if_req`: increment.
- `if_gnt`, or `if_req`=0: clear to 0.
- Never exceeds `MAX_M_STREAK`.

Response owner register `owner`, with states IDLE, RD_IF, RD_M:
- Next state is RD_IF on `if_gnt`.
- Next state is RD_M on `m_gnt & ~m_we`.
- Otherwise next state is IDLE; this includes store grants.
- `if_rvalid` = (`owner`==RD_IF).
- `m_rvalid` = (`owner`==RD_M).
- `if_rdata` = `m_rdata` = `mem_rdata`, passed through combinationally.

Stores produce no response. A store followed back-to-back by a load to the same address returns the new data; this relies on memory write-first ordering across cycles.

## Timing
- Grant: 0 cycles; `gnt` is asserted in the same cycle as a qualifying `req`.
- Read latency: data is presented at cycle N+1 for a grant at cycle N.
- Throughput: one access per cycle, back-to-back, with no bubbles.
- A requester samples `gnt` at the rising edge. It may change `req`/fields only after a cycle with `gnt`=1; withdrawing an ungranted `req` is illegal.

Reset (`rst`=1, asynchronous):
- `streak`=0 and `owner`=IDLE immediately.
- `if_gnt`, `m_gnt`, `mem_en`, `mem_we`, `if_rvalid`, `m_rvalid` are forced to 0 while `rst` is high.
- `stall_f`=`if_req` and `stall_m`=`m_req` while `rst` is high.
- A read granted in the cycle before `rst` asserts returns no `rvalid`.
- After deassertion, the first grant is possible on the same cycle.

Boundary cases:
- `MAX_M_STREAK`=1: strict alternation under continuous contention, M then IF then M.
- Simultaneous requests in the cycle after a fetch grant: `streak` was cleared to 0, so memory stage wins.

## Test plan
- Reset: assert `rst` mid-cycle with `if_req`=`m_req`=1 → all gnt/rvalid/`mem_en` = 0 immediately; `stall_f`=`stall_m`=1; release → `m_gnt`=1 in the same cycle.
- Lone fetch: `if_req`=1, `if_addr`=0x68, `mem_rdata`=0x00500093 next cycle → `if_gnt`=1 at cycle 0, `if_rvalid`=1 with `if_rdata`=0x00500093 at cycle 1, `m_rvalid`=0.
- Store then load: `m_req`=1, `m_we`=1, `m_addr`=0x66, `m_wdata`=0x67; next cycle `m_we`=0 at same address → `mem_we`=1 then 0; no `m_rvalid` after the store; `m_rvalid`=1 with `m_rdata`=0x67 at cycle 2.
- Starvation guard, `MAX_M_STREAK`=4, both requesting for 10 cycles → grant order M,M,M,M,IF,M,M,M,M,IF; `stall_f`=1 exactly in the M-granted cycles.
- Read steering under alternation: M load from 0x10, then IF from 0x20 back-to-back → `m_rvalid` at cycle 1, `if_rvalid` at cycle 2, never both high in one cycle.
- Idle: `if_req`=`m_req`=0 for 5 cycles → `mem_en`=0, `streak`=0, no rvalid, all stalls 0.
